// File: rtl/encoder_4_2_seq.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_4_2_seq
//  Purpose  : Sequential 4-to-2 priority encoder for raw switch/button lines.
//             Each request line is synchronised and then debounced. The
//             highest-priority active line is encoded and presented once per
//             press under a valid/ack handshake.
//  Ports    : clk   - system clock, rising edge
//             rst_n - synchronous active-low reset
//             y     - raw asynchronous request lines, y[3] highest priority
//             w     - registered encoded index of the captured event
//             valid - registered, high while w/multi hold an unacked event
//             multi - registered, more than one filtered line at capture
//             ack   - consumer acknowledge, only honoured in HOLD
//  Revision : 1.0  initial release
// ============================================================================
module encoder_4_2_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] y,
    output logic [1:0] w,
    output logic       valid,
    output logic       multi,
    input  logic       ack
);

    localparam int unsigned c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser: one chain of SYNC_STAGES flops per request bit
    // ------------------------------------------------------------------
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] w_ys;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= y;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_ys = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: a bit must disagree with its filtered value for
    // DEBOUNCE_CYCLES consecutive cycles before the filter follows it.
    // Any agreement restarts the count, so short glitches never pass.
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt [4];
    logic [3:0]         r_yf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_yf <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_ys[i] == r_yf[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_cnt_max) begin
                    r_yf[i]  <= w_ys[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Priority encode of the filtered vector
    // ------------------------------------------------------------------
    logic [1:0] w_enc;
    logic       w_any;
    logic       w_many;

    always_comb begin
        w_enc = 2'd0;
        casez (r_yf)
            4'b1???: w_enc = 2'd3;
            4'b01??: w_enc = 2'd2;
            4'b001?: w_enc = 2'd1;
            default: w_enc = 2'd0;
        endcase
    end

    assign w_any  = |r_yf;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_many = (r_yf & (r_yf - 4'd1)) != 4'd0;

    // ------------------------------------------------------------------
    // Handshake FSM; w/valid/multi are registered alongside the state
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_w;
    logic [1:0] w_w_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_multi;
    logic       w_multi_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_w     <= 2'd0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_valid <= w_valid_nxt;
            r_multi <= w_multi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_valid_nxt = r_valid;
        w_multi_nxt = r_multi;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_w_nxt     = w_enc;
                    w_multi_nxt = w_many;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Index and multi stay frozen here regardless of yf.
                w_valid_nxt = 1'b1;
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                // Full release is required before the next event.
                w_valid_nxt = 1'b0;
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w     = r_w;
    assign valid = r_valid;
    assign multi = r_multi;

endmodule
`default_nettype wire
